// File: rtl/clkdiv_frac_mc.sv
// Multi-channel integer + fractional clock-enable generator using delta-sigma pulse swallowing.
// Define CLKDIV_FRAC_MASH2_EN to build every channel with a 2nd-order MASH 1-1 modulator instead of 1st order.
module clkdiv_frac_mc #(
    parameter int NCH        = 4,
    parameter int W_DIV_INT  = 16,
    parameter int W_DIV_FRAC = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NCH-1:0]              en,
    input  logic                        sync,
    input  logic [NCH*W_DIV_INT-1:0]    div_int,
    input  logic [NCH*W_DIV_FRAC-1:0]   div_frac,
    input  logic [NCH-1:0]              div_load,
    output logic [NCH-1:0]              div_pending,
    output logic [NCH-1:0]              clk_en
);

    localparam logic [W_DIV_INT:0] CTR_ONE = (W_DIV_INT+1)'(1);
`ifdef CLKDIV_FRAC_MASH2_EN
    // The MASH offset can swallow one cycle, so the integer floor is 2 to keep periods >= 1.
    localparam logic [W_DIV_INT:0] MIN_INT = (W_DIV_INT+1)'(2);
`else
    localparam logic [W_DIV_INT:0] MIN_INT = (W_DIV_INT+1)'(1);
`endif

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        logic [W_DIV_INT-1:0]  act_int;
        logic [W_DIV_INT-1:0]  sh_int;
        logic [W_DIV_FRAC-1:0] act_frac;
        logic [W_DIV_FRAC-1:0] sh_frac;
        logic                  pending;
        logic [W_DIV_INT:0]    ctr;
        logic [W_DIV_FRAC-1:0] acc;
        logic                  carry;
        logic                  pulse;

        logic [W_DIV_INT-1:0]  use_int;
        logic [W_DIV_FRAC-1:0] use_frac;
        logic [W_DIV_INT:0]    eff;
        logic [W_DIV_FRAC:0]   acc_sum;
        logic [W_DIV_INT:0]    ctr_reload;
`ifdef CLKDIV_FRAC_MASH2_EN
        logic [W_DIV_FRAC-1:0] acc2;
        logic                  c2;
        logic                  c2_prev;
        logic [W_DIV_FRAC:0]   acc2_sum;
`endif

        // A boundary that finds a pending shadow uses it immediately for this reload.
        always_comb begin
            use_int  = pending ? sh_int : act_int;
            use_frac = pending ? sh_frac : act_frac;
            eff      = {1'b0, use_int};
            if (eff < MIN_INT) begin
                eff = MIN_INT;
            end
            acc_sum = {1'b0, acc} + {1'b0, use_frac};
`ifdef CLKDIV_FRAC_MASH2_EN
            acc2_sum   = {1'b0, acc2} + {1'b0, acc_sum[W_DIV_FRAC-1:0]};
            ctr_reload = eff + {{W_DIV_INT{1'b0}}, carry} + {{W_DIV_INT{1'b0}}, c2}
                         - {{W_DIV_INT{1'b0}}, c2_prev};
`else
            ctr_reload = eff + {{W_DIV_INT{1'b0}}, carry};
`endif
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                act_int  <= W_DIV_INT'(1);
                act_frac <= '0;
                sh_int   <= W_DIV_INT'(1);
                sh_frac  <= '0;
                pending  <= 1'b0;
                ctr      <= CTR_ONE;
                acc      <= '0;
                carry    <= 1'b0;
                pulse    <= 1'b0;
`ifdef CLKDIV_FRAC_MASH2_EN
                acc2     <= '0;
                c2       <= 1'b0;
                c2_prev  <= 1'b0;
`endif
            end else begin
                if (!en[c]) begin
                    pulse <= 1'b0;
                    ctr   <= CTR_ONE;
                    acc   <= '0;
                    carry <= 1'b0;
`ifdef CLKDIV_FRAC_MASH2_EN
                    acc2    <= '0;
                    c2      <= 1'b0;
                    c2_prev <= 1'b0;
`endif
                    if (pending) begin
                        act_int  <= sh_int;
                        act_frac <= sh_frac;
                        pending  <= 1'b0;
                    end
                end else if (sync) begin
                    pulse <= 1'b0;
                    ctr   <= CTR_ONE;
                    acc   <= '0;
                    carry <= 1'b0;
`ifdef CLKDIV_FRAC_MASH2_EN
                    acc2    <= '0;
                    c2      <= 1'b0;
                    c2_prev <= 1'b0;
`endif
                end else if (ctr == CTR_ONE) begin
                    pulse <= 1'b1;
                    if (pending) begin
                        act_int  <= sh_int;
                        act_frac <= sh_frac;
                        pending  <= 1'b0;
                    end
                    acc   <= acc_sum[W_DIV_FRAC-1:0];
                    carry <= acc_sum[W_DIV_FRAC];
                    ctr   <= ctr_reload;
`ifdef CLKDIV_FRAC_MASH2_EN
                    acc2    <= acc2_sum[W_DIV_FRAC-1:0];
                    c2      <= acc2_sum[W_DIV_FRAC];
                    c2_prev <= c2;
`endif
                end else begin
                    pulse <= 1'b0;
                    ctr   <= ctr - CTR_ONE;
                end
                // A load always wins over the pending clear of a coincident boundary.
                if (div_load[c]) begin
                    sh_int  <= div_int[c*W_DIV_INT +: W_DIV_INT];
                    sh_frac <= div_frac[c*W_DIV_FRAC +: W_DIV_FRAC];
                    pending <= 1'b1;
                end
            end
        end

        assign clk_en[c]      = pulse;
        assign div_pending[c] = pending;
    end

endmodule

// File: tb/tb_clkdiv_frac_mc.sv
// Directed bench for clkdiv_frac_mc: expected pulse cycles are queued per channel and matched as pulses appear.
// Honours CLKDIV_FRAC_MASH2_EN to select the matching expectations.
module tb_clkdiv_frac_mc;
    localparam int NCH = 4;
    localparam int WI  = 16;
    localparam int WF  = 8;
`ifdef CLKDIV_FRAC_MASH2_EN
    localparam int P_MIN = 2;
`else
    localparam int P_MIN = 1;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [NCH-1:0]    en = '0;
    logic              sync = 1'b0;
    logic [NCH*WI-1:0] div_int = '0;
    logic [NCH*WF-1:0] div_frac = '0;
    logic [NCH-1:0]    div_load = '0;
    logic [NCH-1:0]    div_pending;
    logic [NCH-1:0]    clk_en;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    logic [31:0] exp_q0[$];
    logic [31:0] exp_q1[$];
    logic [1:0]  mon_on = '0;
    logic        mon_zero2 = 1'b0;
    int          mon_end0 = 0;
    int          mon_end1 = 0;

    clkdiv_frac_mc #(.NCH(NCH), .W_DIV_INT(WI), .W_DIV_FRAC(WF)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .sync        (sync),
        .div_int     (div_int),
        .div_frac    (div_frac),
        .div_load    (div_load),
        .div_pending (div_pending),
        .clk_en      (clk_en)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Pulse monitor: every pulse inside a channel's window must match the head of its queue.
    always @(negedge clk) begin
        logic [31:0] e;
        if (mon_on[0] && clk_en[0] && cyc <= mon_end0) begin
            n_tests++;
            assert (exp_q0.size() != 0) else begin
                n_fail++;
                $error("FAIL ch0_pulse observed=cycle %0d expected=no pulse", cyc);
            end
            if (exp_q0.size() != 0) begin
                e = exp_q0.pop_front();
                assert (32'(cyc) === e) else begin
                    n_fail++;
                    $error("FAIL ch0_pulse observed=cycle %0d expected=cycle %0d", cyc, e);
                end
            end
        end
        if (mon_on[1] && clk_en[1] && cyc <= mon_end1) begin
            n_tests++;
            assert (exp_q1.size() != 0) else begin
                n_fail++;
                $error("FAIL ch1_pulse observed=cycle %0d expected=no pulse", cyc);
            end
            if (exp_q1.size() != 0) begin
                e = exp_q1.pop_front();
                assert (32'(cyc) === e) else begin
                    n_fail++;
                    $error("FAIL ch1_pulse observed=cycle %0d expected=cycle %0d", cyc, e);
                end
            end
        end
        if (mon_zero2) begin
            n_tests++;
            assert (clk_en[2] === 1'b0) else begin
                n_fail++;
                $error("FAIL ch2_idle observed=%b expected=0 at cycle %0d", clk_en[2], cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_until(input int end_cyc);
        while (cyc <= end_cyc) tick(1);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_tests++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic set_div(input int c, input logic [WI-1:0] i, input logic [WF-1:0] f);
        div_int[c*WI +: WI]  = i;
        div_frac[c*WF +: WF] = f;
    endtask

    task automatic load_now(input int c, input logic [WI-1:0] i, input logic [WF-1:0] f);
        set_div(c, i, f);
        div_load[c] = 1'b1;
        tick(1);
        div_load[c] = 1'b0;
    endtask

    // Disable the channel, load a divisor and let the idle channel apply it.
    task automatic prep(input int c, input logic [WI-1:0] i, input logic [WF-1:0] f);
        en[c] = 1'b0;
        tick(1);
        load_now(c, i, f);
        tick(1);
        chk("prep_pending_applied", 32'(div_pending[c]), 32'd0);
    endtask

    initial begin
        int n0;
        int t;
        int k;
        int cnt;
        int last;
        logic gap_ok;

        // Reset state
        tick(3);
        chk("rst_clk_en", 32'(clk_en), 32'd0);
        chk("rst_pending", 32'(div_pending), 32'd0);
        rst_n = 1'b1;
        tick(2);
        chk("post_rst_clk_en", 32'(clk_en), 32'd0);
        chk("post_rst_pending", 32'(div_pending), 32'd0);

        // int=4: first pulse the cycle after en rises, then every 4
        load_now(0, 16'd4, 8'd0);
        chk("t1_pending_set", 32'(div_pending[0]), 32'd1);
        tick(1);
        chk("t1_pending_idle_apply", 32'(div_pending[0]), 32'd0);
        en[0] = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 40;
        for (int i = 0; i < 10; i++) exp_q0.push_back(32'(n0 + 1 + 4 * i));
        mon_on[0] = 1'b1;
        tick(10);
        chk("t1_pending_run", 32'(div_pending[0]), 32'd0);
        wait_until(mon_end0);
        chk("t1_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;

`ifndef CLKDIV_FRAC_MASH2_EN
        // int=3, frac=1/4: one period in four is stretched, with a one-period carry lag
        prep(0, 16'd3, 8'h40);
        en[0] = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 400;
        t = n0 + 1;
        k = 0;
        while (t <= mon_end0) begin
            exp_q0.push_back(32'(t));
            k++;
            t += (k >= 5 && (k % 4) == 1) ? 4 : 3;
        end
        mon_on[0] = 1'b1;
        cnt = 0;
        for (int i = 0; i < 400; i++) begin
            tick(1);
            if (clk_en[0]) cnt++;
        end
        chk("t2_count_123pm1", 32'(cnt >= 122 && cnt <= 124), 32'd1);
        wait_until(mon_end0);
        chk("t2_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;
`else
        // MASH 1-1, int=4, frac=1/2: periods stay within 3..6, average 4.5
        prep(0, 16'd4, 8'h80);
        en[0] = 1'b1;
        n0 = cyc;
        cnt = 0;
        last = -1;
        gap_ok = 1'b1;
        for (int i = 0; i < 1024; i++) begin
            tick(1);
            if (clk_en[0]) begin
                cnt++;
                if (last >= 0 && (cyc - last < 3 || cyc - last > 6)) gap_ok = 1'b0;
                last = cyc;
            end
        end
        chk("t2m_gap_3to6", 32'(gap_ok), 32'd1);
        chk("t2m_count_227_228", 32'(cnt >= 227 && cnt <= 228), 32'd1);
`endif

        // Mid-period loads (5 then 6): last wins, applied at the next boundary
        prep(0, 16'd4, 8'd0);
        en[0] = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 45;
        exp_q0.push_back(32'(n0 + 1));
        exp_q0.push_back(32'(n0 + 5));
        exp_q0.push_back(32'(n0 + 9));
        for (t = n0 + 15; t <= mon_end0; t += 6) exp_q0.push_back(32'(t));
        mon_on[0] = 1'b1;
        tick(6);
        set_div(0, 16'd5, 8'd0);
        div_load[0] = 1'b1;
        tick(1);
        chk("t3_pending_first_load", 32'(div_pending[0]), 32'd1);
        set_div(0, 16'd6, 8'd0);
        tick(1);
        div_load[0] = 1'b0;
        chk("t3_pending_second_load", 32'(div_pending[0]), 32'd1);
        tick(1);
        chk("t3_pending_cleared", 32'(div_pending[0]), 32'd0);
        wait_until(mon_end0);
        chk("t3_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;

        // Load on the boundary cycle: old value for one more period
        prep(0, 16'd4, 8'd0);
        en[0] = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 45;
        exp_q0.push_back(32'(n0 + 1));
        exp_q0.push_back(32'(n0 + 5));
        exp_q0.push_back(32'(n0 + 9));
        for (t = n0 + 15; t <= mon_end0; t += 6) exp_q0.push_back(32'(t));
        mon_on[0] = 1'b1;
        tick(4);
        set_div(0, 16'd6, 8'd0);
        div_load[0] = 1'b1;
        tick(1);
        div_load[0] = 1'b0;
        chk("t4_pending_boundary_load", 32'(div_pending[0]), 32'd1);
        tick(3);
        chk("t4_pending_held", 32'(div_pending[0]), 32'd1);
        tick(1);
        chk("t4_pending_cleared", 32'(div_pending[0]), 32'd0);
        wait_until(mon_end0);
        chk("t4_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;

        // sync: ch0=5 (pending 3), ch1=7 pulse together; ch2 disabled stays quiet
        en = '0;
        tick(1);
        set_div(0, 16'd5, 8'd0);
        set_div(1, 16'd7, 8'd0);
        div_load = 4'b0011;
        tick(1);
        div_load = '0;
        tick(1);
        en[1:0] = 2'b11;
        n0 = cyc;
        mon_end0 = n0 + 60;
        mon_end1 = n0 + 60;
        exp_q0.push_back(32'(n0 + 1));
        exp_q0.push_back(32'(n0 + 6));
        exp_q0.push_back(32'(n0 + 11));
        exp_q0.push_back(32'(n0 + 15));
        for (t = n0 + 18; t <= mon_end0; t += 3) exp_q0.push_back(32'(t));
        exp_q1.push_back(32'(n0 + 1));
        exp_q1.push_back(32'(n0 + 8));
        exp_q1.push_back(32'(n0 + 15));
        for (t = n0 + 22; t <= mon_end1; t += 7) exp_q1.push_back(32'(t));
        mon_on = 2'b11;
        mon_zero2 = 1'b1;
        tick(12);
        set_div(0, 16'd3, 8'd0);
        div_load[0] = 1'b1;
        tick(1);
        div_load[0] = 1'b0;
        sync = 1'b1;
        tick(1);
        sync = 1'b0;
        chk("t5_sync_quiet", 32'(clk_en[1:0]), 32'd0);
        wait_until(mon_end0);
        chk("t5_drained_ch0", 32'(exp_q0.size()), 32'd0);
        chk("t5_drained_ch1", 32'(exp_q1.size()), 32'd0);
        chk("t5_ch2_pending", 32'(div_pending[2]), 32'd0);
        mon_on = '0;
        mon_zero2 = 1'b0;
        en = '0;

        // int=0 behaves as the minimum divisor
        prep(0, 16'd0, 8'd0);
        en[0] = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 20;
        for (t = n0 + 1; t <= mon_end0; t += P_MIN) exp_q0.push_back(32'(t));
        mon_on[0] = 1'b1;
        wait_until(mon_end0);
        chk("t6_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;

        // Asynchronous reset mid-operation clears pending and returns active to 1
        prep(0, 16'd4, 8'd0);
        en[0] = 1'b1;
        tick(6);
        set_div(0, 16'd9, 8'd0);
        div_load[0] = 1'b1;
        tick(1);
        div_load[0] = 1'b0;
        chk("t7_pending_before_rst", 32'(div_pending[0]), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("t7_async_pending", 32'(div_pending), 32'd0);
        chk("t7_async_clk_en", 32'(clk_en), 32'd0);
        tick(1);
        rst_n = 1'b1;
        n0 = cyc;
        mon_end0 = n0 + 8;
        for (t = n0 + 1; t <= mon_end0; t += P_MIN) exp_q0.push_back(32'(t));
        mon_on[0] = 1'b1;
        wait_until(mon_end0);
        chk("t7_drained", 32'(exp_q0.size()), 32'd0);
        mon_on[0] = 1'b0;
        en = '0;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
